// File: rtl/sm_run_ctrl_pkg.sv
// Shared encodings and helpers for the run-control sequencer.
// Imported by sm_tick_gen and sm_run_ctrl.
package sm_run_ctrl_pkg;

  localparam logic [1:0] SM_RC_HALT  = 2'd0;
  localparam logic [1:0] SM_RC_RUN   = 2'd1;
  localparam logic [1:0] SM_RC_STEP  = 2'd2;
  localparam logic [1:0] SM_RC_BREAK = 2'd3;

  localparam int SM_RC_SHIFT = 16;

  typedef struct packed {
    logic [1:0] state;
    logic       en;
  } rc_next_t;

  function automatic logic is_halted(input logic [1:0] s);
    return (s == SM_RC_HALT) || (s == SM_RC_BREAK);
  endfunction

endpackage

// File: rtl/sm_tick_gen.sv
// Programmable power-of-two prescaler producing a registered
// one-cycle tick, or a constant tick when bypassed.
module sm_tick_gen
  import sm_run_ctrl_pkg::*;
#(
  parameter int SHIFT  = SM_RC_SHIFT,
  parameter int BYPASS = 0,
  parameter int CNT_W  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] devide,
  output logic       tick
);

  localparam bit SHIFT_OK = (SHIFT + 15 <= CNT_W - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             tick_q;

  always_comb begin
    term = (CNT_W'(1) << (SHIFT + int'(devide))) - CNT_W'(1);
  end

  // A devide decrease can leave cnt above the new terminal value;
  // restart the period rather than waiting for a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (cnt == term) begin
      cnt    <= '0;
      tick_q <= 1'b1;
    end else if (cnt > term) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick = (BYPASS != 0) ? 1'b1 : tick_q;

  a_shift_fits: assert property (@(posedge clk) SHIFT_OK);

endmodule

// File: rtl/sm_run_ctrl.sv
// HALT/RUN/STEP/BREAK sequencer gating prescaler ticks into a
// registered CPU clock enable, with a retired-cycle counter.
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int SHIFT  = SM_RC_SHIFT,
  parameter int BYPASS = 0,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       devide,
  input  logic             runReq,
  input  logic             stepReq,
  input  logic             haltReq,
  input  logic             bpEnable,
  input  logic [31:0]      bpAddr,
  input  logic [31:0]      pc,
  output logic             cpuEn,
  output logic [1:0]       ctrlState,
  output logic [CNT_W-1:0] cycleCnt,
  output logic             halted
);

  logic       tick;
  logic       step_d;
  logic       step_edge;
  logic       bp_hit;
  logic [1:0] state;
  logic       in_halt;
  logic       in_run;
  logic       in_step;
  logic       in_break;
  rc_next_t   nxt;

  sm_tick_gen #(
    .SHIFT  (SHIFT),
    .BYPASS (BYPASS),
    .CNT_W  (CNT_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .devide (devide),
    .tick   (tick)
  );

  assign step_edge = stepReq & ~step_d;
  assign bp_hit    = bpEnable && (pc == bpAddr);

  assign in_halt  = (state == SM_RC_HALT);
  assign in_run   = (state == SM_RC_RUN);
  assign in_step  = (state == SM_RC_STEP);
  assign in_break = (state == SM_RC_BREAK);

  always_comb begin
    nxt.state = state;
    nxt.en    = 1'b0;
    if (haltReq) begin
      nxt.state = SM_RC_HALT;
    end else begin
      unique case (1'b1)
        in_halt: begin
          if (runReq)
            nxt.state = SM_RC_RUN;
          else if (step_edge)
            nxt.state = SM_RC_STEP;
        end
        in_run: begin
          if (!runReq)
            nxt.state = SM_RC_HALT;
          else if (tick && bp_hit)
            nxt.state = SM_RC_BREAK;
          else if (tick)
            nxt.en = 1'b1;
        end
        // Breakpoint ignored here so a step can leave a BREAK.
        in_step: begin
          if (tick) begin
            nxt.en    = 1'b1;
            nxt.state = SM_RC_HALT;
          end
        end
        in_break: begin
          if (step_edge)
            nxt.state = SM_RC_STEP;
          else if (!runReq)
            nxt.state = SM_RC_HALT;
        end
        default: nxt.state = SM_RC_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SM_RC_HALT;
      cpuEn    <= 1'b0;
      step_d   <= 1'b0;
      halted   <= 1'b1;
      cycleCnt <= '0;
    end else begin
      state  <= nxt.state;
      cpuEn  <= nxt.en;
      step_d <= stepReq;
      halted <= is_halted(nxt.state);
      if (cpuEn)
        cycleCnt <= cycleCnt + CNT_W'(1);
    end
  end

  assign ctrlState = state;

endmodule
